// File: rtl/aes_ctr_stream_ctrl.sv
// Streaming AES-128 CTR controller: feeds one 128-bit block at a time to an
// external single-block engine and presents each result on a ready/valid stream.
module aes_ctr_stream_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [127:0]     cfg_key,
  input  logic [127:0]     cfg_iv,
  input  logic [CNT_W-1:0] cfg_num_blocks,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [127:0]     s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [127:0]     m_data,
  output logic             m_last,
  output logic             eng_start,
  output logic [127:0]     eng_key,
  output logic [127:0]     eng_counter,
  output logic [127:0]     eng_data_in,
  input  logic [127:0]     eng_data_out,
  input  logic             eng_done,
  output logic             busy,
  output logic             done,
  output logic             ctr_wrap
);

  typedef enum logic [2:0] {
    IDLE, GET_IN, START, WAIT_ENG, PUT_OUT, FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     ctr_q, ctr_d;
  logic [127:0]     din_q, din_d;
  logic [127:0]     dout_q, dout_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             wrap_q, wrap_d;
  logic             pend_q, pend_d;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      ctr_q   <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ctr_q   <= ctr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
      pend_q  <= pend_d;
      // done is registered off FINISH, so it lands two cycles after an empty-message start
      done_q  <= (state_q == FINISH);
    end
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    ctr_d     = ctr_q;
    din_d     = din_q;
    dout_d    = dout_q;
    rem_d     = rem_q;
    wrap_d    = wrap_q;
    pend_d    = pend_q;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    eng_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          key_d   = cfg_key;
          ctr_d   = cfg_iv;
          rem_d   = cfg_num_blocks;
          wrap_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = (cfg_num_blocks == '0) ? FINISH : GET_IN;
        end
      end
      GET_IN: begin
        s_ready = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (s_valid) begin
          din_d   = s_data;
          state_d = START;
        end
      end
      START: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          eng_start = 1'b1;
          state_d   = WAIT_ENG;
        end
      end
      WAIT_ENG: begin
        // An abort here cannot stop the engine; remember it and drop the result
        if (abort) pend_d = 1'b1;
        if (eng_done) begin
          if (pend_q || abort) begin
            pend_d  = 1'b0;
            state_d = IDLE;
          end else begin
            dout_d  = eng_data_out;
            ctr_d   = {ctr_q[127:32], ctr_q[31:0] + 32'd1};
            if (ctr_q[31:0] == 32'hFFFF_FFFF) wrap_d = 1'b1;
            rem_d   = rem_q - CNT_W'(1);
            state_d = PUT_OUT;
          end
        end
      end
      PUT_OUT: begin
        m_valid = 1'b1;
        m_last  = (rem_q == '0);
        if (abort) begin
          state_d = IDLE;
        end else if (m_ready) begin
          state_d = (rem_q == '0) ? FINISH : GET_IN;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign ctr_wrap    = wrap_q;
  assign m_data      = dout_q;
  assign eng_key     = key_q;
  assign eng_counter = ctr_q;
  assign eng_data_in = din_q;

endmodule

// File: tb/tb_aes_ctr_stream_ctrl.sv
// Bench for aes_ctr_stream_ctrl: a stub CTR engine plus queue-based scoreboards
// for engine launches and output blocks, driven by directed message scenarios.
module tb_aes_ctr_stream_ctrl;
  localparam int CNT_W = 16;

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] C2  = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [95:0]  A5  = 96'hA5A5A5A5_A5A5A5A5_A5A5A5A5;

  logic             clk;
  logic             rst_n, cfg_start, abort, s_valid, s_ready, m_valid, m_ready, m_last;
  logic [127:0]     cfg_key, cfg_iv, s_data, m_data;
  logic [CNT_W-1:0] cfg_num_blocks;
  logic             eng_start, eng_done, busy, done, ctr_wrap;
  logic [127:0]     eng_key, eng_counter, eng_data_in, eng_data_out;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [383:0] exp_eng_q[$];
  logic [128:0] exp_out_q[$];

  aes_ctr_stream_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_key(cfg_key),
    .cfg_iv(cfg_iv), .cfg_num_blocks(cfg_num_blocks), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .eng_start(eng_start), .eng_key(eng_key), .eng_counter(eng_counter),
    .eng_data_in(eng_data_in), .eng_data_out(eng_data_out), .eng_done(eng_done),
    .busy(busy), .done(done), .ctr_wrap(ctr_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk128(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Keystream returned by the stub engine: true AES output for the two
  // reference counters, bitwise inverse of the counter otherwise.
  function automatic logic [127:0] ks(input logic [127:0] c);
    if (c == IV1) return P1 ^ C1;
    if (c == IV2) return P2 ^ C2;
    return ~c;
  endfunction

  // Stub engine: three cycles from eng_start to a one-cycle eng_done
  int           ecnt = 0;
  logic [127:0] e_ctr, e_din;
  initial begin
    eng_done = 1'b0;
    eng_data_out = '0;
    e_ctr = '0;
    e_din = '0;
    forever begin
      @(negedge clk); #1;
      eng_done = 1'b0;
      if (!rst_n) begin
        ecnt = 0;
      end else if (ecnt > 0) begin
        ecnt--;
        if (ecnt == 0) begin
          chk128("eng_counter_hold", eng_counter, e_ctr);
          chk128("eng_data_in_hold", eng_data_in, e_din);
          eng_done = 1'b1;
          eng_data_out = e_din ^ ks(e_ctr);
        end
      end else if (eng_start) begin
        ecnt = 3;
        e_ctr = eng_counter;
        e_din = eng_data_in;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic [383:0] ee;
    logic [128:0] eo;
    forever begin
      @(negedge clk); #1;
      if (rst_n && eng_start) begin
        if (exp_eng_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL eng_start_unexpected got counter %h expected no launch", eng_counter);
        end else begin
          ee = exp_eng_q.pop_front();
          chk128("eng_key", eng_key, ee[383:256]);
          chk128("eng_counter", eng_counter, ee[255:128]);
          chk128("eng_data_in", eng_data_in, ee[127:0]);
        end
      end
      if (rst_n && m_valid && m_ready) begin
        if (exp_out_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL m_valid_unexpected got data %h expected no output", m_data);
        end else begin
          eo = exp_out_q.pop_front();
          chk128("m_data", m_data, eo[127:0]);
          chk1("m_last", m_last, eo[128]);
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic start_msg(input logic [127:0] k, input logic [127:0] iv, input int n);
    cfg_key = k; cfg_iv = iv; cfg_num_blocks = CNT_W'(n); cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic put_block(input logic [127:0] d);
    int t = 0;
    s_valid = 1'b1; s_data = d;
    while (!s_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk1("s_ready_timeout", 1'b0, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_sig(input string nm, input int which);
    int t = 0;
    while (((which == 0) ? done : m_valid) !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk1(nm, 1'b0, 1'b1);
  endtask

  task automatic check_reset_vals();
    chk1("rst_s_ready", s_ready, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_m_last", m_last, 1'b0);
    chk1("rst_eng_start", eng_start, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ctr_wrap", ctr_wrap, 1'b0);
    chk128("rst_m_data", m_data, '0);
    chk128("rst_eng_key", eng_key, '0);
    chk128("rst_eng_counter", eng_counter, '0);
    chk128("rst_eng_data_in", eng_data_in, '0);
  endtask

  initial begin
    int base;
    logic [127:0] kx, ivx, dx, dy, ivy;
    rst_n = 1'b0; cfg_start = 1'b0; abort = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    cfg_key = '0; cfg_iv = '0; cfg_num_blocks = '0; s_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // Reference vector, two blocks
    base = done_cnt;
    exp_eng_q.push_back({K1, IV1, P1});
    exp_eng_q.push_back({K1, IV2, P2});
    exp_out_q.push_back({1'b0, C1});
    exp_out_q.push_back({1'b1, C2});
    start_msg(K1, IV1, 2);
    chk1("f51_busy", busy, 1'b1);
    put_block(P1);
    put_block(P2);
    wait_sig("f51_done_timeout", 0);
    repeat (2) @(negedge clk);
    chki("f51_done_pulses", done_cnt - base, 1);
    chk1("f51_idle", busy, 1'b0);

    // Counter wrap of the low 32 bits
    kx = 128'h0123456789abcdef0011223344556677;
    ivx = {A5, 32'hFFFF_FFFF};
    ivy = {A5, 32'h0000_0000};
    dx = 128'h11111111222222223333333344444444;
    dy = 128'h55555555666666667777777788888888;
    exp_eng_q.push_back({kx, ivx, dx});
    exp_eng_q.push_back({kx, ivy, dy});
    exp_out_q.push_back({1'b0, dx ^ ~ivx});
    exp_out_q.push_back({1'b1, dy ^ ~ivy});
    start_msg(kx, ivx, 2);
    chk1("wrap_before", ctr_wrap, 1'b0);
    put_block(dx);
    wait_sig("wrap_mvalid_timeout", 1);
    chk1("wrap_after_blk1", ctr_wrap, 1'b1);
    put_block(dy);
    wait_sig("wrap_done_timeout", 0);
    chk1("wrap_sticky", ctr_wrap, 1'b1);
    @(negedge clk);

    // Empty message: done two cycles after cfg_start, wrap cleared
    base = done_cnt;
    start_msg(kx, ivx, 0);
    chk1("empty_busy", busy, 1'b1);
    chk1("empty_done_c1", done, 1'b0);
    chk1("empty_s_ready", s_ready, 1'b0);
    chk1("empty_wrap_clr", ctr_wrap, 1'b0);
    @(negedge clk);
    chk1("empty_done_c2", done, 1'b1);
    @(negedge clk);
    chk1("empty_done_c3", done, 1'b0);
    chki("empty_done_pulses", done_cnt - base, 1);

    // Output backpressure with an ignored cfg_start
    base = done_cnt;
    ivx = 128'h000000000000000000000000_12345678;
    dx = 128'hdeadbeefcafef00d0123456789abcdef;
    exp_eng_q.push_back({kx, ivx, dx});
    exp_out_q.push_back({1'b1, dx ^ ~ivx});
    m_ready = 1'b0;
    start_msg(kx, ivx, 1);
    put_block(dx);
    wait_sig("bp_mvalid_timeout", 1);
    for (int i = 0; i < 5; i++) begin
      chk1("bp_m_valid", m_valid, 1'b1);
      chk128("bp_m_data", m_data, dx ^ ~ivx);
      chk1("bp_s_ready", s_ready, 1'b0);
      cfg_start = (i == 1);
      cfg_num_blocks = '0;
      @(negedge clk);
    end
    cfg_start = 1'b0;
    m_ready = 1'b1;
    wait_sig("bp_done_timeout", 0);
    repeat (3) @(negedge clk);
    chki("bp_done_pulses", done_cnt - base, 1);

    // Abort in GET_IN with simultaneous s_valid
    base = done_cnt;
    start_msg(kx, ivx, 1);
    s_valid = 1'b1; s_data = dx; abort = 1'b1;
    chk1("abget_s_ready", s_ready, 1'b1);
    @(negedge clk);
    s_valid = 1'b0; abort = 1'b0;
    chk1("abget_busy", busy, 1'b0);

    // Abort in START suppresses eng_start
    start_msg(kx, ivx, 1);
    s_valid = 1'b1; s_data = dx;
    @(posedge clk); #1;
    s_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    chk1("abstart_eng_start", eng_start, 1'b0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk1("abstart_busy", busy, 1'b0);

    // Abort in PUT_OUT
    exp_eng_q.push_back({kx, ivx, dy});
    m_ready = 1'b0;
    start_msg(kx, ivx, 1);
    put_block(dy);
    wait_sig("abput_mvalid_timeout", 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk1("abput_m_valid", m_valid, 1'b0);
    chk1("abput_busy", busy, 1'b0);
    m_ready = 1'b1;

    // Abort in WAIT_ENG: result discarded, then a normal message
    exp_eng_q.push_back({kx, ivx, dx});
    start_msg(kx, ivx, 1);
    put_block(dx);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk1("abwait_busy_pending", busy, 1'b1);
    begin
      int t = 0;
      while (t < 20) begin
        @(negedge clk); #2;
        if (eng_done) break;
        t++;
      end
      if (t >= 20) chk1("abwait_eng_done_timeout", 1'b0, 1'b1);
    end
    @(negedge clk);
    chk1("abwait_idle", busy, 1'b0);
    chk1("abwait_m_valid", m_valid, 1'b0);
    chki("abort_no_done", done_cnt - base, 0);
    ivy = 128'h0f0e0d0c0b0a09080706050403020100;
    exp_eng_q.push_back({kx, ivy, dy});
    exp_out_q.push_back({1'b1, dy ^ ~ivy});
    start_msg(kx, ivy, 1);
    put_block(dy);
    wait_sig("abwait_next_done_timeout", 0);
    repeat (2) @(negedge clk);
    chki("abwait_next_done", done_cnt - base, 1);

    // Reset during WAIT_ENG, then a single-block message
    exp_eng_q.push_back({kx, ivx, dx});
    start_msg(kx, ivx, 1);
    put_block(dx);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    base = done_cnt;
    ivy = 128'hffeeddccbbaa99887766554433221100;
    exp_eng_q.push_back({K1, ivy, P1});
    exp_out_q.push_back({1'b1, P1 ^ ~ivy});
    start_msg(K1, ivy, 1);
    put_block(P1);
    wait_sig("rst_next_done_timeout", 0);
    repeat (2) @(negedge clk);
    chki("rst_next_done", done_cnt - base, 1);

    chki("eng_queue_drained", exp_eng_q.size(), 0);
    chki("out_queue_drained", exp_out_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
